lapido_perf_monitor: RTL and testbench

Synthesizable performance monitor for the LAPI DOpaCA LAMBA core. It observes pipeline hazard and control-flow strobes and counts cycles, retired instructions and bubbles, plus N generic event channels. It detects the halt idiom (self-jump), drains the pipeline, and exposes all counters through a registered readout port. It sits beside `lapido_top`, and both synthesis builds and benches use it in place of simulation-only counting.

---
 rtl/lapido_perf_monitor_pkg.sv | 21 ++
 rtl/lapido_sat_counter.sv | 56 +++++
 rtl/lapido_perf_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_lapido_perf_monitor.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lapido_perf_monitor_pkg.sv
// Shared definitions for the LAMBA performance monitor: FSM state
// encodings, readout select codes and overflow bit positions.
package lapido_perf_monitor_pkg;

  typedef enum logic [1:0] {
    PM_IDLE  = 2'd0,
    PM_RUN   = 2'd1,
    PM_DRAIN = 2'd2,
    PM_DONE  = 2'd3
  } pm_state_e;

  localparam logic [3:0] PM_SEL_CYC  = 4'd0;
  localparam logic [3:0] PM_SEL_INST = 4'd1;
  localparam logic [3:0] PM_SEL_BUB  = 4'd2;
  localparam logic [3:0] PM_SEL_HPC  = 4'd3;
  localparam logic [3:0] PM_SEL_EVT0 = 4'd4;

  // Width used to carry a bubble penalty into the bubble counter.
  localparam int PM_PEN_W = 8;

endpackage

// File: rtl/lapido_sat_counter.sv
// Saturating up-counter with a multi-bit increment, synchronous clear and
// a sticky overflow flag. An add that would pass all-ones clamps to all-ones.
module lapido_sat_counter #(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     cnt,
  output logic                 ovf
);

  // The sum is widened so that neither operand can wrap before the clamp test.
  localparam int SUM_W = WIDTH + INC_WIDTH + 1;
  localparam logic [SUM_W-1:0] MAX_EXT = {{(INC_WIDTH + 1){1'b0}}, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum;

  // Next count: clear wins, otherwise add with clamp and sticky overflow.
  always_comb begin
    sum   = {{(INC_WIDTH + 1){1'b0}}, cnt_q} + {{(WIDTH + 1){1'b0}}, inc};
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      if (sum > MAX_EXT) begin
        cnt_d = '1;
        ovf_d = 1'b1;
      end else begin
        cnt_d = sum[WIDTH-1:0];
      end
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/lapido_perf_monitor.sv
// Performance monitor for the LAMBA core: counts cycles, retired
// instructions, bubbles and generic events while running, detects the
// self-jump halt idiom, drains, and offers a registered counter readout.
module lapido_perf_monitor
  import lapido_perf_monitor_pkg::*;
#(
  parameter  int CNT_WIDTH  = 32,
  parameter  int N_EVT      = 4,
  parameter  int PC_WIDTH   = 32,
  parameter  int IMEM_DEPTH = 1024,
  parameter  int HALT_DRAIN = 3,
  parameter  int PEN_JUMP   = 1,
  parameter  int PEN_BRANCH = 3,
  parameter  int PEN_STALL  = 2,
  localparam int EVT_W      = (N_EVT > 0) ? N_EVT : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clr,
  input  logic                 id_is_jump,
  input  logic                 ex_branch_taken,
  input  logic                 hdu_stall,
  input  logic [PC_WIDTH-1:0]  id_jump_addr,
  input  logic [PC_WIDTH-1:0]  if_pc,
  input  logic [EVT_W-1:0]     evt_in,
  input  logic [3:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 running,
  output logic                 done,
  output logic                 err_oob,
  output logic [2+N_EVT:0]     ovf
);

  localparam int DRAIN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(HALT_DRAIN - 1);
  localparam logic [PC_WIDTH:0]  DEPTH_C    = (PC_WIDTH + 1)'(IMEM_DEPTH);

  pm_state_e             state_q, state_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic [PC_WIDTH-1:0]   halt_pc_q, halt_pc_d;
  logic                  err_oob_q, err_oob_d;
  logic [CNT_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic                  halt_det;
  logic                  pc_oob;
  logic                  any_strobe;
  logic                  count_en;
  logic [PM_PEN_W-1:0]   pen;

  logic [CNT_WIDTH-1:0]  cyc_cnt, inst_cnt, bub_cnt, hpc_cnt;
  logic                  ovf_cyc, ovf_inst, ovf_bub;
  logic [CNT_WIDTH-1:0]  evt_cnt [EVT_W];
  logic [EVT_W-1:0]      evt_ovf;

  // Halt is a jump to the word just before the fetch PC (fetch has already
  // advanced past the self-jump); subtraction wraps at PC_WIDTH.
  assign halt_det   = id_is_jump && (id_jump_addr == (if_pc - PC_WIDTH'(1)));
  assign pc_oob     = ({1'b0, if_pc} >= DEPTH_C);
  assign any_strobe = id_is_jump | ex_branch_taken | hdu_stall;
  assign count_en   = (state_q == PM_RUN) && !clr;

  // Bubble penalty, one per cycle, priority jump > branch > stall.
  always_comb begin
    pen = PM_PEN_W'(PEN_STALL);
    if (id_is_jump) begin
      pen = PM_PEN_W'(PEN_JUMP);
    end else if (ex_branch_taken) begin
      pen = PM_PEN_W'(PEN_BRANCH);
    end
  end

  lapido_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_cyc (
    .clk (clk),
    .rst (rst),
    .en  (count_en),
    .clr (clr),
    .inc (1'b1),
    .cnt (cyc_cnt),
    .ovf (ovf_cyc)
  );

  lapido_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_inst (
    .clk (clk),
    .rst (rst),
    .en  (count_en && !any_strobe),
    .clr (clr),
    .inc (1'b1),
    .cnt (inst_cnt),
    .ovf (ovf_inst)
  );

  lapido_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(PM_PEN_W)) u_bub (
    .clk (clk),
    .rst (rst),
    .en  (count_en && any_strobe),
    .clr (clr),
    .inc (pen),
    .cnt (bub_cnt),
    .ovf (ovf_bub)
  );

  generate
    if (N_EVT > 0) begin : g_evt
      for (genvar k = 0; k < N_EVT; k++) begin : g_ch
        lapido_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_evt (
          .clk (clk),
          .rst (rst),
          .en  (count_en && evt_in[k]),
          .clr (clr),
          .inc (1'b1),
          .cnt (evt_cnt[k]),
          .ovf (evt_ovf[k])
        );
      end
      assign ovf = {evt_ovf, ovf_bub, ovf_inst, ovf_cyc};
    end else begin : g_no_evt
      assign evt_cnt[0] = '0;
      assign evt_ovf    = '0;
      assign ovf        = {ovf_bub, ovf_inst, ovf_cyc};
    end
  endgenerate

  // Fit the captured halt PC into a counter-width readout word.
  generate
    if (CNT_WIDTH > PC_WIDTH) begin : g_hpc_ext
      assign hpc_cnt = {{(CNT_WIDTH - PC_WIDTH){1'b0}}, halt_pc_q};
    end else if (CNT_WIDTH == PC_WIDTH) begin : g_hpc_eq
      assign hpc_cnt = halt_pc_q;
    end else begin : g_hpc_trunc
      assign hpc_cnt = halt_pc_q[CNT_WIDTH-1:0];
    end
  endgenerate

  // FSM next state; clear overrides start, halt and out-of-range exits.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    halt_pc_d = halt_pc_q;
    err_oob_d = err_oob_q;
    if (clr) begin
      state_d   = PM_IDLE;
      drain_d   = '0;
      halt_pc_d = '0;
      err_oob_d = 1'b0;
    end else begin
      case (state_q)
        PM_IDLE: begin
          if (start) begin
            state_d = PM_RUN;
          end
        end
        PM_RUN: begin
          if (pc_oob) begin
            state_d   = PM_DONE;
            err_oob_d = 1'b1;
          end else if (halt_det) begin
            state_d   = PM_DRAIN;
            drain_d   = '0;
            halt_pc_d = if_pc;
          end
        end
        PM_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d = PM_DONE;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Readout mux over the current counter values; unmapped selects read 0.
  always_comb begin
    rd_data_d = '0;
    case (rd_sel)
      PM_SEL_CYC:  rd_data_d = cyc_cnt;
      PM_SEL_INST: rd_data_d = inst_cnt;
      PM_SEL_BUB:  rd_data_d = bub_cnt;
      PM_SEL_HPC:  rd_data_d = hpc_cnt;
      default: begin
        for (int k = 0; k < N_EVT; k++) begin
          if (rd_sel == (PM_SEL_EVT0 + 4'(k))) begin
            rd_data_d = evt_cnt[k];
          end
        end
      end
    endcase
  end

  // Control and readout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= PM_IDLE;
      drain_q   <= '0;
      halt_pc_q <= '0;
      err_oob_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      halt_pc_q <= halt_pc_d;
      err_oob_q <= err_oob_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign running = (state_q == PM_RUN);
  assign done    = (state_q == PM_DONE);
  assign err_oob = err_oob_q;

endmodule

// File: tb/tb_lapido_perf_monitor.sv
// Bench for lapido_perf_monitor: a 32-bit main instance and a 4-bit,
// 16-word instance share all stimulus; each phase checks the instance
// whose parameters the scenario targets.
module tb_lapido_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        id_is_jump = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        hdu_stall = 1'b0;
  logic [31:0] id_jump_addr = '0;
  logic [31:0] if_pc = '0;
  logic [1:0]  evt_in = '0;
  logic [3:0]  rd_sel = '0;

  logic [31:0] rd_data_m;
  logic        running_m, done_m, err_m;
  logic [4:0]  ovf_m;
  logic [3:0]  rd_data_s;
  logic        running_s, done_s, err_s;
  logic [4:0]  ovf_s;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    int          which;
    logic [31:0] exp;
  } rd_exp_t;
  rd_exp_t sb[$];

  always #5 clk = ~clk;

  lapido_perf_monitor #(.CNT_WIDTH(32), .N_EVT(2), .PC_WIDTH(32), .IMEM_DEPTH(1024)) dut_m (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .clr             (clr),
    .id_is_jump      (id_is_jump),
    .ex_branch_taken (ex_branch_taken),
    .hdu_stall       (hdu_stall),
    .id_jump_addr    (id_jump_addr),
    .if_pc           (if_pc),
    .evt_in          (evt_in),
    .rd_sel          (rd_sel),
    .rd_data         (rd_data_m),
    .running         (running_m),
    .done            (done_m),
    .err_oob         (err_m),
    .ovf             (ovf_m)
  );

  lapido_perf_monitor #(.CNT_WIDTH(4), .N_EVT(2), .PC_WIDTH(32), .IMEM_DEPTH(16)) dut_s (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .clr             (clr),
    .id_is_jump      (id_is_jump),
    .ex_branch_taken (ex_branch_taken),
    .hdu_stall       (hdu_stall),
    .id_jump_addr    (id_jump_addr),
    .if_pc           (if_pc),
    .evt_in          (evt_in),
    .rd_sel          (rd_sel),
    .rd_data         (rd_data_s),
    .running         (running_s),
    .done            (done_s),
    .err_oob         (err_s),
    .ovf             (ovf_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string tag, input int which, input logic [31:0] exp);
    rd_exp_t e;
    e.tag   = tag;
    e.which = which;
    e.exp   = exp;
    sb.push_back(e);
  endtask

  // Drive the select, let one edge register it, then drain the scoreboard.
  task automatic read_cycle(input logic [3:0] sel);
    rd_exp_t e;
    rd_sel = sel;
    step();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, (e.which == 0) ? rd_data_m : {28'd0, rd_data_s}, e.exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_running_m", {31'd0, running_m}, 32'd0);
    chk("rst_done_m",    {31'd0, done_m},    32'd0);
    chk("rst_err_m",     {31'd0, err_m},     32'd0);
    chk("rst_ovf_m",     {27'd0, ovf_m},     32'd0);
    chk("rst_rd_m",      rd_data_m,          32'd0);
    chk("rst_rd_s",      {28'd0, rd_data_s}, 32'd0);
    rst = 1'b1;
    step();

    // Basic count: 10 clean cycles then halt at pc 21 -> 20
    if_pc = 32'd21;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("basic_running", {31'd0, running_m}, 32'd1);
    for (int i = 0; i < 10; i++) step();
    id_is_jump   = 1'b1;
    id_jump_addr = 32'd20;
    step();
    id_is_jump   = 1'b0;
    id_jump_addr = '0;
    chk("halt_running_fall", {31'd0, running_m}, 32'd0);
    chk("halt_done_m0",      {31'd0, done_m},    32'd0);
    step();
    step();
    chk("halt_done_m2", {31'd0, done_m}, 32'd0);
    step();
    chk("halt_done_m3", {31'd0, done_m}, 32'd1);
    expect_rd("basic_cycles", 0, 32'd11);
    read_cycle(4'd0);
    expect_rd("basic_inst", 0, 32'd10);
    read_cycle(4'd1);
    expect_rd("basic_bub", 0, 32'd1);
    read_cycle(4'd2);
    expect_rd("basic_hpc", 0, 32'd21);
    read_cycle(4'd3);
    chk("basic_done_hold", {31'd0, done_m}, 32'd1);

    // Priority, start ignored in RUN, clr during DRAIN
    clr = 1'b1;
    step();
    clr = 1'b0;
    if_pc = 32'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    id_is_jump = 1'b1; ex_branch_taken = 1'b1; hdu_stall = 1'b1;
    id_jump_addr = 32'd100;
    step();
    id_is_jump = 1'b0;
    step();
    ex_branch_taken = 1'b0; hdu_stall = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_run_running", {31'd0, running_m}, 32'd1);
    id_is_jump   = 1'b1;
    id_jump_addr = 32'd4;
    step();
    id_is_jump   = 1'b0;
    id_jump_addr = '0;
    expect_rd("prio_bub", 0, 32'd5);
    read_cycle(4'd2);
    expect_rd("prio_inst", 0, 32'd1);
    read_cycle(4'd1);
    chk("drain_not_done", {31'd0, done_m}, 32'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_running", {31'd0, running_m}, 32'd0);
    chk("clr_done",    {31'd0, done_m},    32'd0);
    expect_rd("clr_cycles", 0, 32'd0);
    read_cycle(4'd0);
    expect_rd("clr_bub", 0, 32'd0);
    read_cycle(4'd2);
    expect_rd("clr_hpc", 0, 32'd0);
    read_cycle(4'd3);

    // Saturation on the 4-bit instance
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_ovf_cyc_inst", {27'd0, ovf_s}, 32'h03);
    hdu_stall = 1'b1;
    for (int i = 0; i < 7; i++) step();
    hdu_stall = 1'b0;
    chk("sat_ovf_pre_branch", {27'd0, ovf_s}, 32'h03);
    expect_rd("sat_bub14", 1, 32'd14);
    read_cycle(4'd2);
    ex_branch_taken = 1'b1;
    step();
    ex_branch_taken = 1'b0;
    chk("sat_ovf_bub", {27'd0, ovf_s}, 32'h07);
    expect_rd("sat_bub15", 1, 32'd15);
    read_cycle(4'd2);
    expect_rd("sat_cycles15", 1, 32'd15);
    read_cycle(4'd0);
    chk("wide_no_ovf", {27'd0, ovf_m}, 32'd0);

    // Out of bounds on the 16-word instance
    clr = 1'b1;
    step();
    clr = 1'b0;
    if_pc = 32'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if_pc = 32'd16;
    step();
    if_pc = 32'd5;
    chk("oob_err_s",     {31'd0, err_s},     32'd1);
    chk("oob_done_s",    {31'd0, done_s},    32'd1);
    chk("oob_running_s", {31'd0, running_s}, 32'd0);
    chk("oob_err_m",     {31'd0, err_m},     32'd0);
    chk("oob_running_m", {31'd0, running_m}, 32'd1);
    step();
    step();
    expect_rd("oob_cycles_frozen", 1, 32'd4);
    read_cycle(4'd0);
    expect_rd("oob_inst_frozen", 1, 32'd4);
    read_cycle(4'd1);
    chk("oob_done_hold", {31'd0, done_s}, 32'd1);

    // Event readout
    clr = 1'b1;
    step();
    clr = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      evt_in = (i < 2) ? 2'b11 : 2'b10;
      step();
      evt_in = 2'b00;
      step();
    end
    expect_rd("evt1_m", 0, 32'd5);
    expect_rd("evt1_s", 1, 32'd5);
    read_cycle(4'd5);
    expect_rd("evt0_m", 0, 32'd2);
    read_cycle(4'd4);
    expect_rd("sel9_zero", 0, 32'd0);
    read_cycle(4'd9);
    expect_rd("sel15_zero", 0, 32'd0);
    read_cycle(4'd15);

    // Async reset mid-run
    rd_sel = 4'd0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_running_m", {31'd0, running_m}, 32'd0);
    chk("arst_rd_m",      rd_data_m,          32'd0);
    chk("arst_ovf_s",     {27'd0, ovf_s},     32'd0);
    chk("arst_done_s",    {31'd0, done_s},    32'd0);
    #3;
    rst = 1'b1;
    step();
    step();
    step();
    chk("post_rst_idle", {31'd0, running_m}, 32'd0);
    expect_rd("post_rst_cycles_m", 0, 32'd0);
    expect_rd("post_rst_cycles_s", 1, 32'd0);
    read_cycle(4'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
